// File: rtl/mm_pkg.sv
// Shared Mastermind constants, FSM encoding and board slicing helpers,
// used by the game controller and the VGA renderer.
package mm_pkg;

  localparam int ROWS  = 6;
  localparam int COLS  = 4;
  localparam int PEG_W = 3;
  localparam int ROW_W = COLS * PEG_W;
  localparam int FB_W  = 2 * PEG_W;

  localparam logic [2:0] C_EMPTY   = 3'd0;
  localparam logic [2:0] C_BLUE    = 3'd1;
  localparam logic [2:0] C_GREEN   = 3'd2;
  localparam logic [2:0] C_CYAN    = 3'd3;
  localparam logic [2:0] C_RED     = 3'd4;
  localparam logic [2:0] C_YELLOW  = 3'd5;
  localparam logic [2:0] C_MAGENTA = 3'd6;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_INPUT = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  function automatic int row_off(input int r);
    return r * ROW_W;
  endfunction

  function automatic int col_off(input int c);
    return c * PEG_W;
  endfunction

  function automatic logic [2:0] count_color(input logic [ROW_W-1:0] row,
                                             input logic [2:0] color);
    logic [2:0] n;
    n = 3'd0;
    for (int c = 0; c < COLS; c++) begin
      if (row[c*PEG_W +: PEG_W] == color) n = n + 3'd1;
    end
    return n;
  endfunction

  function automatic logic [2:0] min3(input logic [2:0] a, input logic [2:0] b);
    return (a < b) ? a : b;
  endfunction

  // Empty advances to blue; magenta wraps back to blue so 7 is never produced.
  function automatic logic [2:0] next_color(input logic [2:0] c);
    return (c >= C_MAGENTA) ? C_BLUE : c + 3'd1;
  endfunction

endpackage

// File: rtl/mm_lfsr16.sv
// Free-running 16-bit Galois LFSR (x^16 + x^14 + x^13 + x^11 + 1) used as
// the random secret source; shifts right every cycle.
module mm_lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] state_o
);

  logic [15:0] state_q, state_d;

  always_comb begin
    state_d = {1'b0, state_q[15:1]} ^ (state_q[0] ? 16'hB400 : 16'h0000);
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= SEED;
    else       state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/mastermind_game_ctrl.sv
// Mastermind game FSM, board writer and sequential peg scorer.
// Define MM_LFSR_SECRET_EN to draw the secret from the internal LFSR instead of secret_in.
module mastermind_game_ctrl #(
  parameter int          ROWS      = 6,
  parameter int          COLS      = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  btn_left,
  input  logic                  btn_right,
  input  logic                  btn_up,
  input  logic                  btn_center,
  input  logic [COLS*3-1:0]     secret_in,
  output logic [ROWS*COLS*3-1:0] matrix_flat,
  output logic [ROWS*6-1:0]     feedback_flat,
  output logic [2:0]            guess_num,
  output logic [1:0]            cursor_col,
  output logic                  q_Input,
  output logic                  q_Check,
  output logic                  q_Done,
  output logic                  win
);

  import mm_pkg::*;

  localparam logic [2:0] CHECK_LAST = 3'd6;

  state_e                  state_q, state_d;
  logic [ROWS*ROW_W-1:0]   matrix_q, matrix_d;
  logic [ROWS*FB_W-1:0]    feedback_q, feedback_d;
  logic [2:0]              guess_q, guess_d;
  logic [1:0]              cursor_q, cursor_d;
  logic                    win_q, win_d;
  logic [ROW_W-1:0]        secret_q, secret_d;
  logic [2:0]              k_q, k_d;
  logic [2:0]              exact_q, exact_d;
  logic [2:0]              acc_q, acc_d;

  logic [ROW_W-1:0]        secret_src;
  logic [ROW_W-1:0]        cur_row;
  logic [PEG_W-1:0]        cur_slot;
  int                      row_base;
  int                      slot_base;
  logic                    row_full;
  logic [2:0]              exact_now;
  logic [2:0]              acc_sum;
  logic [2:0]              partial;

`ifdef MM_LFSR_SECRET_EN
  logic [15:0] lfsr_state;
  logic [3:0]  unused_lfsr_hi;
  logic [ROW_W-1:0] unused_secret_in;

  mm_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .state_o (lfsr_state)
  );

  // 0..5 -> 1..6, 6..7 -> 1..2 keeps every secret peg a real color.
  for (genvar gi = 0; gi < COLS; gi++) begin : g_secret
    logic [2:0] v;
    assign v = lfsr_state[gi*PEG_W +: PEG_W];
    assign secret_src[gi*PEG_W +: PEG_W] = (v < 3'd6) ? v + 3'd1 : v - 3'd5;
  end

  assign unused_lfsr_hi   = lfsr_state[15:12];
  assign unused_secret_in = secret_in;
`else
  logic [15:0] unused_seed;

  for (genvar gi = 0; gi < COLS; gi++) begin : g_secret
    logic [2:0] f;
    assign f = secret_in[gi*PEG_W +: PEG_W];
    assign secret_src[gi*PEG_W +: PEG_W] = (f == C_EMPTY || f == 3'd7) ? C_BLUE : f;
  end

  assign unused_seed = LFSR_SEED;
`endif

  always_comb begin
    state_d    = state_q;
    matrix_d   = matrix_q;
    feedback_d = feedback_q;
    guess_d    = guess_q;
    cursor_d   = cursor_q;
    win_d      = win_q;
    secret_d   = secret_q;
    k_d        = k_q;
    exact_d    = exact_q;
    acc_d      = acc_q;

    row_base  = row_off(int'(guess_q));
    slot_base = row_base + col_off(int'(cursor_q));
    cur_row   = matrix_q[row_base +: ROW_W];
    cur_slot  = matrix_q[slot_base +: PEG_W];

    row_full  = 1'b1;
    exact_now = 3'd0;
    for (int c = 0; c < COLS; c++) begin
      if (cur_row[c*PEG_W +: PEG_W] == C_EMPTY) row_full = 1'b0;
      if (cur_row[c*PEG_W +: PEG_W] == secret_q[c*PEG_W +: PEG_W]) exact_now = exact_now + 3'd1;
    end

    acc_sum = acc_q + min3(count_color(secret_q, k_q), count_color(cur_row, k_q));
    partial = acc_sum - exact_q;

    if (start && state_q != S_CHECK) begin
      matrix_d   = '0;
      feedback_d = '0;
      guess_d    = 3'd0;
      cursor_d   = 2'd0;
      win_d      = 1'b0;
      secret_d   = secret_src;
      state_d    = S_INPUT;
    end else begin
      case (state_q)
        S_INPUT: begin
          // A pressed center blocks the other buttons even when the row is incomplete.
          if (btn_center) begin
            if (row_full) begin
              state_d = S_CHECK;
              k_d     = 3'd0;
              exact_d = 3'd0;
              acc_d   = 3'd0;
            end
          end else if (btn_up) begin
            matrix_d[slot_base +: PEG_W] = next_color(cur_slot);
          end else if (btn_left && !btn_right) begin
            cursor_d = cursor_q - 2'd1;
          end else if (btn_right && !btn_left) begin
            cursor_d = cursor_q + 2'd1;
          end
        end
        S_CHECK: begin
          k_d = k_q + 3'd1;
          if (k_q == 3'd0) exact_d = exact_now;
          else             acc_d   = acc_sum;
          if (k_q == CHECK_LAST) begin
            k_d = 3'd0;
            feedback_d[int'(guess_q)*FB_W +: FB_W] = {partial, exact_q};
            if (exact_q == 3'(COLS)) begin
              state_d = S_DONE;
              win_d   = 1'b1;
            end else if (guess_q == 3'(ROWS-1)) begin
              state_d = S_DONE;
              win_d   = 1'b0;
            end else begin
              guess_d  = guess_q + 3'd1;
              cursor_d = 2'd0;
              state_d  = S_INPUT;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_INIT;
      matrix_q   <= '0;
      feedback_q <= '0;
      guess_q    <= 3'd0;
      cursor_q   <= 2'd0;
      win_q      <= 1'b0;
      secret_q   <= '0;
      k_q        <= 3'd0;
      exact_q    <= 3'd0;
      acc_q      <= 3'd0;
    end else begin
      state_q    <= state_d;
      matrix_q   <= matrix_d;
      feedback_q <= feedback_d;
      guess_q    <= guess_d;
      cursor_q   <= cursor_d;
      win_q      <= win_d;
      secret_q   <= secret_d;
      k_q        <= k_d;
      exact_q    <= exact_d;
      acc_q      <= acc_d;
    end
  end

  assign matrix_flat   = matrix_q;
  assign feedback_flat = feedback_q;
  assign guess_num     = guess_q;
  assign cursor_col    = cursor_q;
  assign win           = win_q;
  assign q_Input       = (state_q == S_INPUT);
  assign q_Check       = (state_q == S_CHECK);
  assign q_Done        = (state_q == S_DONE);

endmodule

// File: tb/tb_mastermind_game_ctrl.sv
// Directed and randomized bench for mastermind_game_ctrl against a game-rule
// reference model (board arrays, direct peg counting).
module tb_mastermind_game_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        btn_left = 1'b0;
  logic        btn_right = 1'b0;
  logic        btn_up = 1'b0;
  logic        btn_center = 1'b0;
  logic [11:0] secret_in = 12'h0;
  logic [71:0] matrix_flat;
  logic [35:0] feedback_flat;
  logic [2:0]  guess_num;
  logic [1:0]  cursor_col;
  logic        q_Input, q_Check, q_Done, win;

  mastermind_game_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .btn_left      (btn_left),
    .btn_right     (btn_right),
    .btn_up        (btn_up),
    .btn_center    (btn_center),
    .secret_in     (secret_in),
    .matrix_flat   (matrix_flat),
    .feedback_flat (feedback_flat),
    .guess_num     (guess_num),
    .cursor_col    (cursor_col),
    .q_Input       (q_Input),
    .q_Check       (q_Check),
    .q_Done        (q_Done),
    .win           (win)
  );

  always #20 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model state: 0 INIT, 1 INPUT, 2 CHECK, 3 DONE.
  int m_board[6][4];
  int m_fbp[6];
  int m_fbe[6];
  int m_secret[4];
  int m_guess, m_cursor, m_state, m_win;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    logic [71:0] em;
    logic [35:0] ef;
    em = '0;
    ef = '0;
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 4; c++) em[r*12 + c*3 +: 3] = 3'(m_board[r][c]);
      ef[r*6 +: 6] = {3'(m_fbp[r]), 3'(m_fbe[r])};
    end
    chk({tag, ":matrix"},   72'(matrix_flat),   em);
    chk({tag, ":feedback"}, 72'(feedback_flat), 72'(ef));
    chk({tag, ":guess"},    72'(guess_num),     72'(m_guess));
    chk({tag, ":cursor"},   72'(cursor_col),    72'(m_cursor));
    chk({tag, ":q_Input"},  72'(q_Input),       72'(m_state == 1));
    chk({tag, ":q_Check"},  72'(q_Check),       72'(m_state == 2));
    chk({tag, ":q_Done"},   72'(q_Done),        72'(m_state == 3));
    chk({tag, ":win"},      72'(win),           72'(m_win));
  endtask

  task automatic model_clear();
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 4; c++) m_board[r][c] = 0;
      m_fbp[r] = 0;
      m_fbe[r] = 0;
    end
    m_guess = 0;
    m_cursor = 0;
    m_win = 0;
  endtask

  task automatic model_start(input logic [11:0] s);
    int v;
    model_clear();
    for (int c = 0; c < 4; c++) begin
      v = int'(s[c*3 +: 3]);
      m_secret[c] = (v == 0 || v == 7) ? 1 : v;
    end
    m_state = 1;
  endtask

  task automatic model_score();
    int ex, tot, cs, cg;
    ex = 0;
    tot = 0;
    for (int c = 0; c < 4; c++) if (m_board[m_guess][c] == m_secret[c]) ex++;
    for (int col = 1; col <= 6; col++) begin
      cs = 0;
      cg = 0;
      for (int c = 0; c < 4; c++) begin
        if (m_secret[c] == col) cs++;
        if (m_board[m_guess][c] == col) cg++;
      end
      tot += (cs < cg) ? cs : cg;
    end
    m_fbe[m_guess] = ex;
    m_fbp[m_guess] = tot - ex;
    if (ex == 4) begin
      m_state = 3;
      m_win = 1;
    end else if (m_guess == 5) begin
      m_state = 3;
      m_win = 0;
    end else begin
      m_guess++;
      m_cursor = 0;
      m_state = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One button cycle; an accepted submit also waits through the whole CHECK.
  task automatic press(input string tag, input bit s, input bit c, input bit u,
                       input bit l, input bit r, input logic [11:0] sec);
    bit accepted;
    bit full;
    accepted = 0;
    start = s;
    btn_center = c;
    btn_up = u;
    btn_left = l;
    btn_right = r;
    secret_in = sec;
    if (s && m_state != 2) begin
      model_start(sec);
    end else if (m_state == 1) begin
      if (c) begin
        full = 1;
        for (int i = 0; i < 4; i++) if (m_board[m_guess][i] == 0) full = 0;
        if (full) begin
          accepted = 1;
          m_state = 2;
        end
      end else if (u) begin
        m_board[m_guess][m_cursor] = (m_board[m_guess][m_cursor] >= 6) ? 1 : m_board[m_guess][m_cursor] + 1;
      end else if (l && !r) begin
        m_cursor = (m_cursor + 3) % 4;
      end else if (r && !l) begin
        m_cursor = (m_cursor + 1) % 4;
      end
    end
    tick();
    start = 0;
    btn_center = 0;
    btn_up = 0;
    btn_left = 0;
    btn_right = 0;
    if (accepted) begin
      for (int i = 0; i < 7; i++) begin
        chk({tag, ":check_busy"}, 72'(q_Check), 72'(1));
        tick();
      end
      model_score();
    end
    compare_all(tag);
  endtask

  task automatic enter_row(input string tag, input logic [11:0] g, input bit submit);
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < int'(g[c*3 +: 3]); k++) press(tag, 0, 0, 1, 0, 0, 12'h0);
      press(tag, 0, 0, 0, 0, 1, 12'h0);
    end
    if (submit) press(tag, 0, 1, 0, 0, 0, 12'h0);
  endtask

  function automatic logic [11:0] pack(input int a, input int b, input int c, input int d);
    return {3'(d), 3'(c), 3'(b), 3'(a)};
  endfunction

  function automatic logic [11:0] rand_code();
    logic [11:0] v;
    for (int c = 0; c < 4; c++) v[c*3 +: 3] = 3'($urandom_range(1, 6));
    return v;
  endfunction

  initial begin
    logic [11:0] sec, g;
    int r;
    model_clear();
    m_state = 0;

    reset = 1;
    tick();
    tick();
    compare_all("reset");
    reset = 0;
    tick();
    compare_all("idle");

    // Perfect first guess.
    press("start1234", 1, 0, 0, 0, 0, pack(1, 2, 3, 4));
    enter_row("win_row", pack(1, 2, 3, 4), 1);
    chk("win_fb", 72'(feedback_flat[5:0]), 72'({3'd0, 3'd4}));
    chk("win_flag", 72'(win), 72'(1));
    chk("win_guess", 72'(guess_num), 72'(0));

    // Partial-only and mixed scoring.
    press("start1122", 1, 0, 0, 0, 0, pack(1, 1, 2, 2));
    enter_row("g2211", pack(2, 2, 1, 1), 1);
    chk("fb_4_0", 72'(feedback_flat[5:0]), 72'({3'd4, 3'd0}));
    enter_row("g1212", pack(1, 2, 1, 2), 1);
    chk("fb_2_2", 72'(feedback_flat[11:6]), 72'({3'd2, 3'd2}));
    chk("guess_2", 72'(guess_num), 72'(2));

    // Incomplete submit, color wrap, cursor edges, center+up priority.
    press("start_edge", 1, 0, 0, 0, 0, pack(3, 4, 5, 6));
    for (int c = 0; c < 3; c++) begin
      press("fill", 0, 0, 1, 0, 0, 12'h0);
      press("fill", 0, 0, 0, 0, 1, 12'h0);
    end
    press("sub_empty", 0, 1, 0, 0, 0, 12'h0);
    chk("sub_empty_input", 72'(q_Input), 72'(1));
    chk("sub_empty_guess", 72'(guess_num), 72'(0));
    for (int i = 0; i < 7; i++) press("up_wrap", 0, 0, 1, 0, 0, 12'h0);
    chk("up_wrap_slot", 72'(matrix_flat[11:9]), 72'(1));
    press("right_wrap", 0, 0, 0, 0, 1, 12'h0);
    chk("right_wrap", 72'(cursor_col), 72'(0));
    press("left_wrap", 0, 0, 0, 1, 0, 12'h0);
    chk("left_wrap", 72'(cursor_col), 72'(3));
    press("left_right", 0, 0, 0, 1, 1, 12'h0);
    chk("left_right", 72'(cursor_col), 72'(3));
    press("center_up", 0, 1, 1, 0, 0, 12'h0);
    chk("center_up_color", 72'(matrix_flat[11:9]), 72'(1));
    chk("center_up_fb", 72'(feedback_flat[5:0]), 72'({3'd0, 3'd0}));

    // Six losing guesses.
    sec = rand_code();
    press("start_lose", 1, 0, 0, 0, 0, sec);
    for (int row = 0; row < 6; row++) begin
      do g = rand_code(); while (g == sec);
      enter_row("lose_row", g, 1);
    end
    chk("lose_done", 72'(q_Done), 72'(1));
    chk("lose_win", 72'(win), 72'(0));
    chk("lose_guess", 72'(guess_num), 72'(5));
    press("done_up", 0, 0, 1, 0, 0, 12'h0);
    press("done_center", 0, 1, 0, 1, 0, 12'h0);
    press("restart", 1, 0, 0, 0, 0, rand_code());
    chk("restart_matrix", matrix_flat, 72'(0));
    chk("restart_input", 72'(q_Input), 72'(1));

    // Random button traffic, raw secrets may contain 0 or 7.
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2)       press("rnd_start", 1, 0, 0, 0, 0, 12'($urandom_range(0, 4095)));
      else if (r < 12) press("rnd_center", 0, 1, 0, 0, 0, 12'h0);
      else if (r < 55) press("rnd_up", 0, 0, 1, 0, 0, 12'h0);
      else if (r < 70) press("rnd_left", 0, 0, 0, 1, 0, 12'h0);
      else if (r < 85) press("rnd_right", 0, 0, 0, 0, 1, 12'h0);
      else if (r < 90) press("rnd_lr", 0, 0, 0, 1, 1, 12'h0);
      else if (r < 93) press("rnd_cu", 0, 1, 1, 0, 0, 12'h0);
      else             press("rnd_idle", 0, 0, 0, 0, 0, 12'h0);
    end

    // Reset in the middle of CHECK.
    press("start_rst", 1, 0, 0, 0, 0, rand_code());
    enter_row("rst_row", rand_code(), 0);
    btn_center = 1;
    tick();
    btn_center = 0;
    chk("rst_in_check", 72'(q_Check), 72'(1));
    tick();
    tick();
    reset = 1;
    tick();
    model_clear();
    m_state = 0;
    compare_all("rst_mid_check");
    reset = 0;
    press("start_after_rst", 1, 0, 0, 0, 0, rand_code());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mastermind_game_ctrl.md
# mastermind_game_ctrl

Game controller and board writer for the FPGA Mastermind design. It captures a 4-peg secret and takes player guesses from debounced single-cycle button pulses. It scores each submitted guess with a sequential exact/partial peg counter, and maintains the board state (`matrix_flat`, `guess_num`, `q_Input`) that the VGA renderer reads every pixel clock. It sits between the button debouncers and the VGA renderer, in the same 25 MHz pixel-clock domain.

## Interface
Parameters:
- `ROWS`, 6: number of guess rows; `guess_num` range is 0..ROWS-1.
- `COLS`, 4: pegs per row; peg field is 3 bits.
- `LFSR_SEED`, 16'hACE1: reset value of the secret LFSR. Must be nonzero.

Ports:
- `clk`  in  1  pixel clock, ≈25 MHz; single clock domain.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  pulse: begin a new game.
- `btn_left` / `btn_right`  in  1  pulse: move the cursor column.
- `btn_up`  in  1  pulse: cycle the color of the peg under the cursor.
- `btn_center`  in  1  pulse: submit the current row.
- `secret_in`  in  12  external secret, `[c*3+:3]` is column c; sampled on `start`.
- `matrix_flat`  out  72  board; row r is `[r*12+:12]`, column c is `[c*3+:3]`.
- `feedback_flat`  out  36  scores; row r is `[r*6+:6]` = {partial[2:0], exact[2:0]}.
- `guess_num`  out  3  current row, 0..5.
- `cursor_col`  out  2  active column.
- `q_Input`, `q_Check`, `q_Done`  out  1  one-hot state flags. All three are low in INIT.
- `win`  out  1  valid when `q_Done` is high.

## Operation
- Color codes: 0 = empty, 1 = blue, 2 = green, 3 = cyan, 4 = red, 5 = yellow, 6 = magenta. Code 7 is never written.
- FSM states: INIT, INPUT, CHECK, DONE. Reset enters INIT.
- `start` is honored in INIT, INPUT and DONE, and ignored in CHECK. When honored it:
  - clears `matrix_flat`, `feedback_flat`, `guess_num`, `cursor_col` and `win`;
  - latches the secret;
  - moves the FSM to INPUT.
- INPUT, with button priority center > up > left/right. If left and right arrive together, neither acts.
  - `btn_up` on the slot at (`guess_num`, `cursor_col`): 0→1, 1→2, …, 6→1.
  - `btn_left`: 0 wraps to 3. `btn_right`: 3 wraps to 0.
  - `btn_center` is accepted only if all 4 slots of the current row are nonzero; otherwise it is ignored with no state change. When accepted, the FSM moves to CHECK.
- CHECK is a 7-cycle step counter k = 0..6:
  - k = 0: exact = number of columns where guess equals secret.
  - k = 1..6: acc += min(count of color k in secret, count of color k in guess).
  - After k = 6: partial = acc − exact. Write {partial, exact} to the feedback slot for `guess_num`.
  - Then: if exact == 4, go to DONE with `win` = 1. Else if `guess_num` == 5, go to DONE with `win` = 0. Else increment `guess_num`, set `cursor_col` to 0, and go to INPUT.
- Arithmetic widths: per-color counts 3 bits (0..4); acc 3 bits, which cannot exceed 4; exact/partial 3 bits.
- DONE: the board is frozen and all buttons are ignored except `start`.
- All buttons except `start` are ignored outside INPUT.
- Reset mid-game (any state): next cycle all outputs are 0 and the FSM is in INIT.

## Timing
- All outputs are registered. Button or `start` in cycle N gives the visible effect in cycle N+1.
- Accepted `btn_center` in cycle N: `q_Input` low and `q_Check` high at N+1. Feedback row and next state are visible at N+8.
- Reset values: `matrix_flat` = 0, `feedback_flat` = 0, `guess_num` = 0, `cursor_col` = 0, all `q_*` = 0, `win` = 0. The LFSR resets to `LFSR_SEED`.
- The LFSR advances every cycle, including in reset-released idle.

## Configuration
- `MM_LFSR_SECRET_EN` defined:
  - On `start`, the secret is taken from the internal 16-bit Galois LFSR, taps 16, 14, 13, 11.
  - Column c uses LFSR bits `[c*3+:3]`, mapped as v → (v < 6 ? v + 1 : v − 5).
  - `secret_in` is ignored.
- `MM_LFSR_SECRET_EN` undefined:
  - On `start`, `secret_in` is latched verbatim, except that fields equal to 0 or 7 are stored as 1.
  - The LFSR is not instantiated.

## Structure
- Package `mm_pkg` holds:
  - the color code constants;
  - the FSM state encoding;
  - `ROWS`, `COLS` and `PEG_W` = 3;
  - the row/column slice-offset helper functions shared with the VGA renderer.
- Sub-module `mm_lfsr16` holds the LFSR (clk, reset, seed parameter, 16-bit state out). It is instantiated only under `MM_LFSR_SECRET_EN`.

## Test plan
- Start with secret 1-2-3-4, then enter 1-2-3-4 and submit → `q_Check` high for 7 cycles; `feedback_flat[5:0]` = {0, 4}; `q_Done` = 1; `win` = 1; `guess_num` stays 0.
- Secret 1-1-2-2, guess 2-2-1-1 → row 0 feedback {4, 0}. Guess 1-2-1-2 → row 1 feedback {2, 2}. `guess_num` ends at 2.
- Submit with slot 3 empty → ignored; `q_Input` stays 1 and `guess_num` stays 0. Pressing `btn_up` seven times on an empty slot leaves code 1, showing the 6→1 wrap.
- Cursor: `btn_left` from column 0 → 3. `btn_left` and `btn_right` in the same cycle → no change. `btn_center` and `btn_up` in the same cycle on a full row → submit only, color unchanged.
- Six wrong guesses → after the sixth CHECK, `q_Done` = 1, `win` = 0, `guess_num` = 5. Then `start` → board and feedback zero, `q_Input` = 1.
- Assert `reset` during CHECK → next cycle all outputs 0 and FSM in INIT. Under `MM_LFSR_SECRET_EN`, `start` at a fixed cycle count after reset yields the same secret on every run.
